// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared mode constants and parameter legality check for the occupancy counter
package contador_pkg;

  localparam bit MODE_SAT  = 1'b0;
  localparam bit MODE_WRAP = 1'b1;

  // True when MAX fits in WIDTH bits and the thresholds sit inside the range.
  function automatic bit params_ok(input int width, input int max,
                                   input int ae_thresh, input int af_thresh);
    longint unsigned lim;
    lim = (longint'(1) << width) - 1;
    return (width >= 1) && (max >= 1) && (longint'(max) <= lim) &&
           (ae_thresh >= 0) && (ae_thresh < max) &&
           (af_thresh > 0) && (af_thresh <= max);
  endfunction

endpackage

// File: rtl/contador_nbits_flags.sv
// rtl/contador_nbits_flags.sv - combinational occupancy decodes of a count value
module contador_nbits_flags #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 15,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = 12
) (
  input  logic [WIDTH-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] AE_W  = WIDTH'(AE_THRESH);
  localparam logic [WIDTH-1:0] AF_W  = WIDTH'(AF_THRESH);

  assign empty        = (count == '0);
  assign full         = (count == MAX_W);
  assign almost_empty = (count <= AE_W);
  assign almost_full  = (count >= AF_W);

endmodule

// File: rtl/contador_nbits.sv
// rtl/contador_nbits.sv - parametrised up/down occupancy counter with range, modes and sticky errors
module contador_nbits
  import contador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX       = 15,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = 12,
  parameter bit WRAP      = MODE_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             ovf,
  output logic             udf
);

  generate
    if (!params_ok(WIDTH, MAX, AE_THRESH, AF_THRESH)) begin : g_illegal_params
      $error("contador_nbits: illegal WIDTH/MAX/threshold combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, udf_q;
  logic             ovf_evt, udf_evt;
  logic [WIDTH:0]   cnt_x, inc_x, dec_x, load_x;

  assign cnt_x  = {1'b0, count_q};
  assign inc_x  = cnt_x + 1'b1;
  assign dec_x  = cnt_x - 1'b1;
  assign load_x = {1'b0, load_val};

  // Bit WIDTH of dec_x is the borrow out, i.e. the counter was already at zero.
  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_x > MAX_X) begin
        count_d = MAX_W;
        ovf_evt = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en && inc && !dec) begin
      if (inc_x <= MAX_X) begin
        count_d = inc_x[WIDTH-1:0];
      end else begin
        count_d = (WRAP == MODE_WRAP) ? '0 : MAX_W;
        ovf_evt = 1'b1;
      end
    end else if (en && dec && !inc) begin
      if (!dec_x[WIDTH]) begin
        count_d = dec_x[WIDTH-1:0];
      end else begin
        count_d = (WRAP == MODE_WRAP) ? MAX_W : '0;
        udf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_evt | (ovf_q & ~err_clr);
      udf_q   <= udf_evt | (udf_q & ~err_clr);
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  contador_nbits_flags #(
    .WIDTH     (WIDTH),
    .MAX       (MAX),
    .AE_THRESH (AE_THRESH),
    .AF_THRESH (AF_THRESH)
  ) u_flags (
    .count        (count_q),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

endmodule

// File: tb/tb_contador_nbits.sv
// tb/tb_contador_nbits.sv - self-checking bench for contador_nbits across saturate, wrap and clamp instances
module tb_contador_nbits;

  localparam int N = 3;
  localparam int P_MAX  [N] = '{15, 9, 10};
  localparam int P_AE   [N] = '{2, 2, 3};
  localparam int P_AF   [N] = '{12, 7, 8};
  localparam bit P_WRAP [N] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, inc = 1'b0, dec = 1'b0, err_clr = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_o [N];
  logic       empty_o [N], full_o [N], ae_o [N], af_o [N], ovf_o [N], udf_o [N];

  int checks = 0;
  int errors = 0;

  int m_cnt [N];
  bit m_ovf [N];
  bit m_udf [N];

  always #5 clk = ~clk;

  contador_nbits #(.WIDTH(4), .MAX(15), .AE_THRESH(2), .AF_THRESH(12), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .inc(inc), .dec(dec), .err_clr(err_clr), .count(cnt_o[0]), .empty(empty_o[0]),
    .full(full_o[0]), .almost_empty(ae_o[0]), .almost_full(af_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0]));

  contador_nbits #(.WIDTH(4), .MAX(9), .AE_THRESH(2), .AF_THRESH(7), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .inc(inc), .dec(dec), .err_clr(err_clr), .count(cnt_o[1]), .empty(empty_o[1]),
    .full(full_o[1]), .almost_empty(ae_o[1]), .almost_full(af_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1]));

  contador_nbits #(.WIDTH(4), .MAX(10), .AE_THRESH(3), .AF_THRESH(8), .WRAP(1'b0)) dut_m10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .inc(inc), .dec(dec), .err_clr(err_clr), .count(cnt_o[2]), .empty(empty_o[2]),
    .full(full_o[2]), .almost_empty(ae_o[2]), .almost_full(af_o[2]), .ovf(ovf_o[2]), .udf(udf_o[2]));

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Reference: signed net change against the [0, MAX] range.
  task automatic model_step(input int k);
    int n;
    bit eo, eu;
    eo = 0; eu = 0;
    if (clr) m_cnt[k] = 0;
    else if (load) begin
      if (int'(load_val) > P_MAX[k]) begin m_cnt[k] = P_MAX[k]; eo = 1; end
      else m_cnt[k] = int'(load_val);
    end else if (en) begin
      n = m_cnt[k] + int'(inc) - int'(dec);
      if (n > P_MAX[k]) begin m_cnt[k] = P_WRAP[k] ? 0 : P_MAX[k]; eo = 1; end
      else if (n < 0) begin m_cnt[k] = P_WRAP[k] ? P_MAX[k] : 0; eu = 1; end
      else m_cnt[k] = n;
    end
    m_ovf[k] = eo || (m_ovf[k] && !err_clr);
    m_udf[k] = eu || (m_udf[k] && !err_clr);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, ".count"}, k, int'(cnt_o[k]), m_cnt[k]);
      chk({tag, ".ovf"}, k, int'(ovf_o[k]), int'(m_ovf[k]));
      chk({tag, ".udf"}, k, int'(udf_o[k]), int'(m_udf[k]));
      chk({tag, ".empty"}, k, int'(empty_o[k]), int'(m_cnt[k] == 0));
      chk({tag, ".full"}, k, int'(full_o[k]), int'(m_cnt[k] == P_MAX[k]));
      chk({tag, ".almost_empty"}, k, int'(ae_o[k]), int'(m_cnt[k] <= P_AE[k]));
      chk({tag, ".almost_full"}, k, int'(af_o[k]), int'(m_cnt[k] >= P_AF[k]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e,
                       input bit i, input bit d, input bit ec);
    clr = c; load = l; load_val = 4'(lv); en = e; inc = i; dec = d; err_clr = ec;
  endtask

  typedef struct {
    bit c, l; int lv; bit e, i, d, ec;
    int exp_cnt; bit exp_ovf, exp_udf;
  } vec_t;

  vec_t vt [17];

  initial begin
    // Expectations below are for the saturating MAX=15 instance.
    vt[0]  = '{0,1,5, 0,0,0,0,  5,0,0};
    vt[1]  = '{1,1,9, 1,1,0,0,  0,0,0};
    vt[2]  = '{0,1,3, 1,1,0,0,  3,0,0};
    vt[3]  = '{0,0,0, 1,1,0,0,  4,0,0};
    vt[4]  = '{0,0,0, 1,1,1,0,  4,0,0};
    vt[5]  = '{0,0,0, 0,1,0,0,  4,0,0};
    vt[6]  = '{0,0,0, 1,0,1,0,  3,0,0};
    vt[7]  = '{0,1,14,0,0,0,0, 14,0,0};
    vt[8]  = '{0,0,0, 1,1,0,0, 15,0,0};
    vt[9]  = '{0,0,0, 1,1,1,0, 15,0,0};
    vt[10] = '{0,0,0, 1,1,0,0, 15,1,0};
    vt[11] = '{0,0,0, 1,1,0,1, 15,1,0};
    vt[12] = '{0,0,0, 0,0,0,1, 15,0,0};
    vt[13] = '{1,0,0, 0,0,0,0,  0,0,0};
    vt[14] = '{0,0,0, 1,1,1,0,  0,0,0};
    vt[15] = '{0,0,0, 1,0,1,0,  0,0,1};
    vt[16] = '{0,0,0, 0,0,0,1,  0,0,0};

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int t = 0; t < 17; t++) begin
      drive(vt[t].c, vt[t].l, vt[t].lv, vt[t].e, vt[t].i, vt[t].d, vt[t].ec);
      tick($sformatf("vec%0d", t));
      chk($sformatf("vec%0d.tbl_count", t), 0, int'(cnt_o[0]), vt[t].exp_cnt);
      chk($sformatf("vec%0d.tbl_ovf", t), 0, int'(ovf_o[0]), int'(vt[t].exp_ovf));
      chk($sformatf("vec%0d.tbl_udf", t), 0, int'(udf_o[0]), int'(vt[t].exp_udf));
    end

    // Saturating climb: almost_full at 12, full at 15, 16th inc clamps and flags.
    drive(1, 0, 0, 0, 0, 0, 1);
    tick("sat.clr");
    for (int p = 1; p <= 16; p++) begin
      drive(0, 0, 0, 1, 1, 0, 0);
      tick($sformatf("sat.inc%0d", p));
      if (p == 12) chk("sat.af_at_12", 0, int'(af_o[0]), 1);
      if (p == 11) chk("sat.af_at_11", 0, int'(af_o[0]), 0);
      if (p == 15) chk("sat.full_at_15", 0, int'(full_o[0]), 1);
      if (p == 15) chk("sat.no_ovf_at_15", 0, int'(ovf_o[0]), 0);
    end
    chk("sat.hold15", 0, int'(cnt_o[0]), 15);
    chk("sat.ovf16", 0, int'(ovf_o[0]), 1);

    // Wrap instance: underflow to MAX, then overflow back to zero.
    drive(1, 0, 0, 0, 0, 0, 1);
    tick("wrap.clr");
    drive(0, 0, 0, 1, 0, 1, 0);
    tick("wrap.dec0");
    chk("wrap.dec_to_max", 1, int'(cnt_o[1]), 9);
    chk("wrap.udf", 1, int'(udf_o[1]), 1);
    drive(0, 0, 0, 1, 1, 0, 0);
    tick("wrap.inc9");
    chk("wrap.inc_to_zero", 1, int'(cnt_o[1]), 0);
    chk("wrap.ovf", 1, int'(ovf_o[1]), 1);

    // Asynchronous reset mid-cycle at count 7.
    drive(0, 1, 7, 0, 0, 0, 0);
    tick("pre_rst.load7");
    drive(0, 0, 0, 1, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_held");
    rst_n = 1'b1;

    for (int r = 0; r < 1500; r++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 15),
            ($urandom_range(0, 4) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 11) == 0));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
